// File: rtl/chan_mux_arb_if.sv
// Handshake bundle for chan_mux_arb: per-channel producer inputs and the single
// registered consumer output, plus mode/select control and the transfer count.
interface chan_mux_arb_if #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
);
    logic                      mode;
    logic [SEL_W-1:0]          select;
    logic [CHANNELS*WIDTH-1:0] in_data;
    logic [CHANNELS-1:0]       in_valid;
    logic [CHANNELS-1:0]       in_ready;
    logic [WIDTH-1:0]          out_data;
    logic [SEL_W-1:0]          out_chan;
    logic                      out_valid;
    logic                      out_ready;
    logic [15:0]               xfer_count;

    modport master (
        output mode, select, in_data, in_valid, out_ready,
        input  in_ready, out_data, out_chan, out_valid, xfer_count
    );

    modport slave (
        input  mode, select, in_data, in_valid, out_ready,
        output in_ready, out_data, out_chan, out_valid, xfer_count
    );
endinterface

// File: rtl/chan_mux_arb.sv
// Registered N:1 channel mux with directed-select or round-robin arbitration and
// a one-entry output register. Define CHAN_MUX_XFER_COUNT_EN to build the output transfer counter.
module chan_mux_arb #(
    parameter int WIDTH    = 32,
    parameter int CHANNELS = 8,
    parameter int SEL_W    = 3
) (
    input  logic          clk,
    input  logic          rst_n,
    chan_mux_arb_if.slave bus
);

    logic                w_loadEn;
    logic                w_grantValid;
    logic [SEL_W-1:0]    w_grant;
    logic [WIDTH-1:0]    w_grantData;
    logic [CHANNELS-1:0] w_inReady;

    logic [WIDTH-1:0]    r_outData;
    logic [SEL_W-1:0]    r_outChan;
    logic                r_outValid;
    logic [SEL_W-1:0]    r_rrLast;

    assign w_loadEn = !r_outValid || bus.out_ready;

    // Round-robin scans from the channel after the last winner, wrapping, so the
    // loop over scan offsets keeps only the first valid channel it meets.
    always_comb begin
        w_grant      = '0;
        w_grantValid = 1'b0;
        if (bus.mode == 1'b0) begin
            for (int k = 0; k < CHANNELS; k++) begin
                if (bus.select == SEL_W'(k) && bus.in_valid[k]) begin
                    w_grant      = SEL_W'(k);
                    w_grantValid = 1'b1;
                end
            end
        end else begin
            for (int i = 1; i <= CHANNELS; i++) begin
                for (int k = 0; k < CHANNELS; k++) begin
                    if (!w_grantValid && bus.in_valid[k] &&
                        k == ((int'(r_rrLast) + i) % CHANNELS)) begin
                        w_grant      = SEL_W'(k);
                        w_grantValid = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        w_grantData = '0;
        w_inReady   = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_grant == SEL_W'(k)) begin
                w_grantData  = bus.in_data[k*WIDTH +: WIDTH];
                w_inReady[k] = w_grantValid && w_loadEn && rst_n;
            end
        end
    end

    // A fresh load takes priority over draining, giving one word per cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_outData  <= '0;
            r_outChan  <= '0;
            r_outValid <= 1'b0;
            r_rrLast   <= SEL_W'(CHANNELS - 1);
        end else if (w_grantValid && w_loadEn) begin
            r_outData  <= w_grantData;
            r_outChan  <= w_grant;
            r_outValid <= 1'b1;
            r_rrLast   <= w_grant;
        end else if (bus.out_ready) begin
            r_outValid <= 1'b0;
        end
    end

`ifdef CHAN_MUX_XFER_COUNT_EN
    logic [15:0] r_xferCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_xferCount <= '0;
        end else if (r_outValid && bus.out_ready) begin
            r_xferCount <= r_xferCount + 16'd1;
        end
    end

    assign bus.xfer_count = r_xferCount;
`else
    assign bus.xfer_count = 16'h0000;
`endif

    assign bus.in_ready  = w_inReady;
    assign bus.out_data  = r_outData;
    assign bus.out_chan  = r_outChan;
    assign bus.out_valid = r_outValid;

endmodule

// File: tb/tb_chan_mux_arb.sv
// Self-checking bench for chan_mux_arb: table-driven vectors on an 8-channel
// instance plus hand sequences for the 5-channel bound, async reset and counter.
module tb_chan_mux_arb;

    typedef struct {
        logic        mode;
        logic [2:0]  sel;
        logic [7:0]  inValid;
        logic        outReady;
        logic [7:0]  expInReady;
        logic        expOutValid;
        logic [31:0] expOutData;
        logic [2:0]  expOutChan;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    logic [31:0] dataVals [8];
    vec_t        vecs [$];

    chan_mux_arb_if #(.WIDTH(32), .CHANNELS(8), .SEL_W(3)) bus8 ();
    chan_mux_arb_if #(.WIDTH(32), .CHANNELS(5), .SEL_W(3)) bus5 ();

    chan_mux_arb #(.WIDTH(32), .CHANNELS(8), .SEL_W(3)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    chan_mux_arb #(.WIDTH(32), .CHANNELS(5), .SEL_W(3)) dut5 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus5)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic mode, input logic [2:0] sel,
                                 input logic [7:0] inValid, input logic outReady);
        bus8.mode      = mode;
        bus8.select    = sel;
        bus8.in_valid  = inValid;
        bus8.out_ready = outReady;
    endtask

    function automatic vec_t makeVec(input logic mode, input logic [2:0] sel,
                                     input logic [7:0] inValid, input logic outReady,
                                     input logic [7:0] expInReady, input logic expOutValid,
                                     input int dataIdx, input logic [2:0] expOutChan);
        vec_t v;
        v.mode        = mode;
        v.sel         = sel;
        v.inValid     = inValid;
        v.outReady    = outReady;
        v.expInReady  = expInReady;
        v.expOutValid = expOutValid;
        v.expOutData  = dataVals[dataIdx];
        v.expOutChan  = expOutChan;
        return v;
    endfunction

    initial begin
        int rrOrder [6];
        dataVals = '{32'h00000000, 32'h11111111, 32'h33333333, 32'h77777777,
                     32'hFFFFFFFF, 32'h55555555, 32'hAAAAAAAA, 32'h66666666};
        rrOrder  = '{0, 2, 5, 7, 0, 2};

        // Directed sweep, each channel loaded in turn
        for (int k = 0; k < 8; k++)
            vecs.push_back(makeVec(1'b0, 3'(k), 8'hFF, 1'b1, 8'(1 << k), 1'b1, k, 3'(k)));
        // Round-robin over channels 0,2,5,7
        for (int i = 0; i < 6; i++)
            vecs.push_back(makeVec(1'b1, 3'd0, 8'hA5, 1'b1, 8'(1 << rrOrder[i]), 1'b1,
                                   rrOrder[i], 3'(rrOrder[i])));
        // Load channel 3 then stall for four cycles
        vecs.push_back(makeVec(1'b0, 3'd3, 8'h08, 1'b1, 8'h08, 1'b1, 3, 3'd3));
        for (int i = 0; i < 4; i++)
            vecs.push_back(makeVec(1'b0, 3'd3, 8'hFF, 1'b0, 8'h00, 1'b1, 3, 3'd3));
        // Drain and load channel 6 in the same cycle
        vecs.push_back(makeVec(1'b0, 3'd6, 8'h40, 1'b1, 8'h40, 1'b1, 6, 3'd6));
        // Selected channel not valid: no grant, output drains, data holds
        vecs.push_back(makeVec(1'b0, 3'd2, 8'hFB, 1'b1, 8'h00, 1'b0, 6, 3'd6));
        // Switch to round-robin with rr_last retained at 6
        vecs.push_back(makeVec(1'b1, 3'd2, 8'hFF, 1'b1, 8'h80, 1'b1, 7, 3'd7));
        vecs.push_back(makeVec(1'b1, 3'd0, 8'h80, 1'b1, 8'h80, 1'b1, 7, 3'd7));
        vecs.push_back(makeVec(1'b1, 3'd0, 8'h00, 1'b1, 8'h00, 1'b0, 7, 3'd7));

        for (int k = 0; k < 8; k++) bus8.in_data[k*32 +: 32] = dataVals[k];
        for (int k = 0; k < 5; k++) bus5.in_data[k*32 +: 32] = dataVals[k];
        applyStimulus(1'b0, 3'd0, 8'hFF, 1'b1);
        bus5.mode      = 1'b0;
        bus5.select    = 3'd0;
        bus5.in_valid  = 5'h00;
        bus5.out_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        checkOutput("reset_out_valid", 32'(bus8.out_valid), 32'd0);
        checkOutput("reset_out_data", bus8.out_data, 32'd0);
        checkOutput("reset_out_chan", 32'(bus8.out_chan), 32'd0);
        checkOutput("reset_in_ready", 32'(bus8.in_ready), 32'd0);
        checkOutput("reset_xfer_count", 32'(bus8.xfer_count), 32'd0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].mode, vecs[i].sel, vecs[i].inValid, vecs[i].outReady);
            #1;
            checkOutput($sformatf("vec%0d_in_ready", i), 32'(bus8.in_ready), 32'(vecs[i].expInReady));
            @(posedge clk);
            #1;
            checkOutput($sformatf("vec%0d_out_valid", i), 32'(bus8.out_valid), 32'(vecs[i].expOutValid));
            checkOutput($sformatf("vec%0d_out_data", i), bus8.out_data, vecs[i].expOutData);
            checkOutput($sformatf("vec%0d_out_chan", i), 32'(bus8.out_chan), 32'(vecs[i].expOutChan));
`ifndef CHAN_MUX_XFER_COUNT_EN
            checkOutput($sformatf("vec%0d_xfer_count", i), 32'(bus8.xfer_count), 32'd0);
`endif
            @(negedge clk);
        end

        // Five-channel instance: select 6 is out of range
        bus5.select   = 3'd6;
        bus5.in_valid = 5'h1F;
        #1;
        checkOutput("ch5_sel6_in_ready", 32'(bus5.in_ready), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("ch5_sel6_out_valid", 32'(bus5.out_valid), 32'd0);
        @(negedge clk);
        bus5.select = 3'd4;
        #1;
        checkOutput("ch5_sel4_in_ready", 32'(bus5.in_ready), 32'h10);
        @(posedge clk);
        #1;
        checkOutput("ch5_sel4_out_data", bus5.out_data, 32'hFFFFFFFF);
        checkOutput("ch5_sel4_out_chan", 32'(bus5.out_chan), 32'd4);
        @(negedge clk);
        bus5.in_valid = 5'h00;

        // Asynchronous reset while channel 5 is held in the output register
        applyStimulus(1'b1, 3'd0, 8'h20, 1'b0);
        @(posedge clk);
        #1;
        checkOutput("prereset_out_chan", 32'(bus8.out_chan), 32'd5);
        checkOutput("prereset_out_valid", 32'(bus8.out_valid), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset_out_valid", 32'(bus8.out_valid), 32'd0);
        checkOutput("midreset_out_data", bus8.out_data, 32'd0);
        checkOutput("midreset_in_ready", 32'(bus8.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 3'd0, 8'hFF, 1'b1);
        #1;
        checkOutput("postreset_in_ready", 32'(bus8.in_ready), 32'h01);
        @(posedge clk);
        #1;
        checkOutput("postreset_out_chan", 32'(bus8.out_chan), 32'd0);
        checkOutput("postreset_out_valid", 32'(bus8.out_valid), 32'd1);
        @(posedge clk);
        #1;
        checkOutput("postreset_next_chan", 32'(bus8.out_chan), 32'd1);
        checkOutput("postreset_next_data", bus8.out_data, 32'h11111111);

`ifdef CHAN_MUX_XFER_COUNT_EN
        // Fresh start: 10 loads give 9 transfers, one drain cycle makes 10
        @(negedge clk);
        rst_n = 1'b0;
        applyStimulus(1'b1, 3'd0, 8'h00, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        bus8.in_valid = 8'hFF;
        repeat (10) @(posedge clk);
        @(negedge clk);
        bus8.in_valid = 8'h00;
        @(posedge clk);
        #1;
        checkOutput("count_10", 32'(bus8.xfer_count), 32'd10);
        @(negedge clk);
        bus8.in_valid = 8'hFF;
        repeat (65526) @(posedge clk);
        #1;
        checkOutput("count_ffff", 32'(bus8.xfer_count), 32'h0000FFFF);
        @(posedge clk);
        #1;
        checkOutput("count_wrap", 32'(bus8.xfer_count), 32'd0);
`else
        checkOutput("count_disabled", 32'(bus8.xfer_count), 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
